// File: rtl/control_pkg.sv
// Shared encodings, pipeline control-bundle types and the condition-code
// evaluator for the pipelined ARM control unit.
package control_pkg;

    typedef enum logic [1:0] {
        OP_DP   = 2'b00,
        OP_MEM  = 2'b01,
        OP_BR   = 2'b10,
        OP_NONE = 2'b11
    } op_e;

    typedef enum logic [3:0] {
        CMD_AND = 4'b0000,
        CMD_SUB = 4'b0010,
        CMD_ADD = 4'b0100,
        CMD_CMP = 4'b1010,
        CMD_ORR = 4'b1100,
        CMD_MOV = 4'b1101
    } cmd_e;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    typedef enum logic [1:0] {
        EXT_DP_IMM  = 2'b00,
        EXT_MEM_IMM = 2'b01,
        EXT_BRANCH  = 2'b10
    } ext_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_W   = 2'b01,
        FWD_M   = 2'b10
    } fwd_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       memtoreg;
        logic       branch;
        logic       link;
        logic       pcs;
        logic       flag_write;
        logic       alu_src;
        logic [3:0] alu_ctrl;
        logic [3:0] cond;
    } ctrl_e_t;

    typedef struct packed {
        logic reg_write;
        logic mem_write;
        logic memtoreg;
        logic pcs;
        logic link;
    } ctrl_mw_t;

    // flags are packed {C, V, N, Z}
    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] flags);
        logic c, v, n, z;
        logic ok;
        {c, v, n, z} = flags;
        case (cond)
            COND_EQ: ok = z;
            COND_NE: ok = ~z;
            COND_CS: ok = c;
            COND_CC: ok = ~c;
            COND_MI: ok = n;
            COND_PL: ok = ~n;
            COND_VS: ok = v;
            COND_VC: ok = ~v;
            COND_HI: ok = c & ~z;
            COND_LS: ok = ~c | z;
            COND_GE: ok = (n == v);
            COND_LT: ok = (n != v);
            COND_GT: ok = ~z & (n == v);
            COND_LE: ok = z | (n != v);
            COND_AL: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/pipelined_control_unit_if.sv
// Datapath <-> control-unit signal bundle; master is the datapath side,
// slave is the control unit.
interface pipelined_control_unit_if;
    logic [1:0] OP;
    logic [5:0] FUNCT;
    logic [3:0] COND;
    logic [3:0] Rd;
    logic [3:0] Flags;
    logic [3:0] RA1D;
    logic [3:0] RA2D;
    logic [3:0] RA1E;
    logic [3:0] RA2E;
    logic [3:0] WA3E;
    logic [3:0] WA3M;
    logic [3:0] WA3W;

    logic       RA1_select;
    logic       RA2_select;
    logic [1:0] extender_select;
    logic       shifter_input_select;
    logic       shifter_amount_select;
    logic       shifter_type_select;
    logic [3:0] ALU_control;
    logic       ALUsrcE;
    logic       PC_select_W;
    logic       data_memory_write_enable;
    logic       Register_file_write_enable;
    logic       MemtoregW;
    logic       R14_select;
    logic       PC_select;
    logic [1:0] ForwardAE;
    logic [1:0] ForwardBE;
    logic       StallF;
    logic       StallD;
    logic       FlushD;
    logic       FlushE;

    modport master (
        output OP, FUNCT, COND, Rd, Flags,
        output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
        input  RA1_select, RA2_select, extender_select,
        input  shifter_input_select, shifter_amount_select, shifter_type_select,
        input  ALU_control, ALUsrcE, PC_select_W, data_memory_write_enable,
        input  Register_file_write_enable, MemtoregW, R14_select, PC_select,
        input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE
    );

    modport slave (
        input  OP, FUNCT, COND, Rd, Flags,
        input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
        output RA1_select, RA2_select, extender_select,
        output shifter_input_select, shifter_amount_select, shifter_type_select,
        output ALU_control, ALUsrcE, PC_select_W, data_memory_write_enable,
        output Register_file_write_enable, MemtoregW, R14_select, PC_select,
        output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE
    );
endinterface

// File: rtl/pipelined_control_unit_hazard.sv
// Combinational forwarding, stall and flush generation.
module hazard_unit
    import control_pkg::*;
(
    input  logic [3:0] i_ra1d,
    input  logic [3:0] i_ra2d,
    input  logic [3:0] i_ra1e,
    input  logic [3:0] i_ra2e,
    input  logic [3:0] i_wa3e,
    input  logic [3:0] i_wa3m,
    input  logic [3:0] i_wa3w,
    input  logic       i_reg_write_e,
    input  logic       i_memtoreg_e,
    input  logic       i_reg_write_m,
    input  logic       i_link_m,
    input  logic       i_reg_write_w,
    input  logic       i_link_w,
    input  logic       i_pcs_d,
    input  logic       i_pcs_e,
    input  logic       i_pcs_m,
    input  logic       i_pcs_w,
    input  logic       i_pc_select_w,
    output logic [1:0] o_forward_ae,
    output logic [1:0] o_forward_be,
    output logic       o_stall_f,
    output logic       o_stall_d,
    output logic       o_flush_d,
    output logic       o_flush_e
);

    logic w_fwd_m_ok;
    logic w_fwd_w_ok;
    logic w_ldr_stall;
    logic w_pc_wr_pending;

    // a link write targets R14 through a separate path, so it never forwards
    assign w_fwd_m_ok = i_reg_write_m & ~i_link_m;
    assign w_fwd_w_ok = i_reg_write_w & ~i_link_w;

    always_comb begin
        o_forward_ae = FWD_REG;
        if (w_fwd_m_ok && (i_ra1e == i_wa3m)) begin
            o_forward_ae = FWD_M;
        end else if (w_fwd_w_ok && (i_ra1e == i_wa3w)) begin
            o_forward_ae = FWD_W;
        end
    end

    always_comb begin
        o_forward_be = FWD_REG;
        if (w_fwd_m_ok && (i_ra2e == i_wa3m)) begin
            o_forward_be = FWD_M;
        end else if (w_fwd_w_ok && (i_ra2e == i_wa3w)) begin
            o_forward_be = FWD_W;
        end
    end

    assign w_ldr_stall     = i_memtoreg_e & i_reg_write_e & ((i_ra1d == i_wa3e) | (i_ra2d == i_wa3e));
    assign w_pc_wr_pending = i_pcs_d | i_pcs_e | i_pcs_m;

    assign o_stall_f = w_ldr_stall | w_pc_wr_pending;
    assign o_stall_d = w_ldr_stall;
    assign o_flush_d = w_pc_wr_pending | i_pcs_w | i_pc_select_w;
    assign o_flush_e = w_ldr_stall | i_pc_select_w;

endmodule

// File: rtl/pipelined_control_unit.sv
// Decode, E/M/W control pipeline, NZCV flags register and conditional
// execution for the 5-stage ARM datapath.
module pipelined_control_unit
    import control_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    pipelined_control_unit_if.slave  ctrl_bus
);

    ctrl_e_t    w_dec;
    logic       w_ra1_select;
    logic       w_ra2_select;
    logic [1:0] w_ext_select;

    ctrl_e_t    r_ctrl_e;
    ctrl_mw_t   w_mw_e;
    ctrl_mw_t   r_ctrl_m;
    ctrl_mw_t   r_ctrl_w;
    logic [3:0] r_flags;
    logic       w_cond_ex;
    logic       w_pc_select_w;

    logic [1:0] w_forward_ae;
    logic [1:0] w_forward_be;
    logic       w_stall_f;
    logic       w_stall_d;
    logic       w_flush_d;
    logic       w_flush_e;

    always_comb begin
        w_dec        = '0;
        w_ra1_select = 1'b0;
        w_ra2_select = 1'b0;
        w_ext_select = EXT_DP_IMM;
        case (ctrl_bus.OP)
            OP_DP: begin
                w_dec.alu_ctrl = ctrl_bus.FUNCT[4:1];
                w_dec.alu_src  = ctrl_bus.FUNCT[5];
                case (ctrl_bus.FUNCT[4:1])
                    CMD_AND, CMD_SUB, CMD_ADD, CMD_ORR, CMD_MOV: begin
                        w_dec.reg_write  = 1'b1;
                        w_dec.flag_write = ctrl_bus.FUNCT[0];
                    end
                    CMD_CMP: w_dec.flag_write = 1'b1;
                    default: ;
                endcase
            end
            OP_MEM: begin
                w_dec.alu_ctrl = CMD_ADD;
                w_dec.alu_src  = 1'b1;
                w_ext_select   = EXT_MEM_IMM;
                if (ctrl_bus.FUNCT[0]) begin
                    w_dec.reg_write = 1'b1;
                    w_dec.memtoreg  = 1'b1;
                end else begin
                    w_dec.mem_write = 1'b1;
                    w_ra2_select    = 1'b1;
                end
            end
            OP_BR: begin
                w_ra1_select    = 1'b1;
                w_ext_select    = EXT_BRANCH;
                w_dec.alu_src   = 1'b1;
                w_dec.alu_ctrl  = CMD_ADD;
                w_dec.branch    = 1'b1;
                w_dec.link      = ctrl_bus.FUNCT[4];
                w_dec.reg_write = ctrl_bus.FUNCT[4];
            end
            default: ;
        endcase
        w_dec.pcs  = w_dec.reg_write & (ctrl_bus.Rd == 4'd15) & ~w_dec.link;
        w_dec.cond = ctrl_bus.COND;
    end

    always_ff @(posedge clk) begin
        if (reset || w_flush_e) begin
            r_ctrl_e <= '0;
        end else begin
            r_ctrl_e <= w_dec;
        end
    end

    assign w_cond_ex     = cond_holds(r_ctrl_e.cond, r_flags);
    assign w_pc_select_w = r_ctrl_e.branch & w_cond_ex;

    // a branch-and-link also needs its return-address write gated by CondEx
    assign w_mw_e.reg_write = r_ctrl_e.reg_write & w_cond_ex;
    assign w_mw_e.mem_write = r_ctrl_e.mem_write & w_cond_ex;
    assign w_mw_e.memtoreg  = r_ctrl_e.memtoreg;
    assign w_mw_e.pcs       = r_ctrl_e.pcs & w_cond_ex;
    assign w_mw_e.link      = r_ctrl_e.link & w_cond_ex;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= '0;
        end else if (r_ctrl_e.flag_write && w_cond_ex) begin
            r_flags <= ctrl_bus.Flags;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl_m <= '0;
            r_ctrl_w <= '0;
        end else begin
            r_ctrl_m <= w_mw_e;
            r_ctrl_w <= r_ctrl_m;
        end
    end

    hazard_unit u_hazard (
        .i_ra1d        (ctrl_bus.RA1D),
        .i_ra2d        (ctrl_bus.RA2D),
        .i_ra1e        (ctrl_bus.RA1E),
        .i_ra2e        (ctrl_bus.RA2E),
        .i_wa3e        (ctrl_bus.WA3E),
        .i_wa3m        (ctrl_bus.WA3M),
        .i_wa3w        (ctrl_bus.WA3W),
        .i_reg_write_e (r_ctrl_e.reg_write),
        .i_memtoreg_e  (r_ctrl_e.memtoreg),
        .i_reg_write_m (r_ctrl_m.reg_write),
        .i_link_m      (r_ctrl_m.link),
        .i_reg_write_w (r_ctrl_w.reg_write),
        .i_link_w      (r_ctrl_w.link),
        .i_pcs_d       (w_dec.pcs),
        .i_pcs_e       (r_ctrl_e.pcs),
        .i_pcs_m       (r_ctrl_m.pcs),
        .i_pcs_w       (r_ctrl_w.pcs),
        .i_pc_select_w (w_pc_select_w),
        .o_forward_ae  (w_forward_ae),
        .o_forward_be  (w_forward_be),
        .o_stall_f     (w_stall_f),
        .o_stall_d     (w_stall_d),
        .o_flush_d     (w_flush_d),
        .o_flush_e     (w_flush_e)
    );

    assign ctrl_bus.RA1_select                 = w_ra1_select;
    assign ctrl_bus.RA2_select                 = w_ra2_select;
    assign ctrl_bus.extender_select            = w_ext_select;
    assign ctrl_bus.shifter_input_select       = 1'b0;
    assign ctrl_bus.shifter_amount_select      = 1'b0;
    assign ctrl_bus.shifter_type_select        = 1'b0;
    assign ctrl_bus.ALU_control                = r_ctrl_e.alu_ctrl;
    assign ctrl_bus.ALUsrcE                    = r_ctrl_e.alu_src;
    assign ctrl_bus.PC_select_W                = w_pc_select_w;
    assign ctrl_bus.data_memory_write_enable   = r_ctrl_m.mem_write;
    assign ctrl_bus.Register_file_write_enable = r_ctrl_w.reg_write;
    assign ctrl_bus.MemtoregW                  = r_ctrl_w.memtoreg;
    assign ctrl_bus.R14_select                 = r_ctrl_w.link;
    assign ctrl_bus.PC_select                  = r_ctrl_w.pcs;
    assign ctrl_bus.ForwardAE                  = w_forward_ae;
    assign ctrl_bus.ForwardBE                  = w_forward_be;
    assign ctrl_bus.StallF                     = w_stall_f;
    assign ctrl_bus.StallD                     = w_stall_d;
    assign ctrl_bus.FlushD                     = w_flush_d;
    assign ctrl_bus.FlushE                     = w_flush_e;

endmodule
